// File: rtl/irq_pkg.sv
// Shared types and helpers for the request latch and its priority-encoder model.
// Optional build macro IRQ_REQ_SYNC_EN adds a 2-flop synchronizer on req_in.
package irq_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int IDX_W_DEF = 2;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } irq_state_t;

    // Highest set bit wins, matching the downstream encoder; returns 0 for an empty vector.
    function automatic logic [IDX_W_DEF-1:0] highest_idx(input logic [N_REQ_DEF-1:0] v);
        logic [IDX_W_DEF-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ_DEF; i++) begin
            if (v[i]) idx = IDX_W_DEF'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/req_edge_detect.sv
// Rising-edge detector for the raw request lines, with an optional per-line
// 2-flop synchronizer in front when IRQ_REQ_SYNC_EN is defined.
module req_edge_detect #(
    parameter int N_REQ = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_in,
    output logic [N_REQ-1:0] req_edge
);

    logic [N_REQ-1:0] req_s;
    logic [N_REQ-1:0] req_q;

`ifdef IRQ_REQ_SYNC_EN
    logic [N_REQ-1:0] sync1;
    logic [N_REQ-1:0] sync2;

    for (genvar i = 0; i < N_REQ; i++) begin : g_sync
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1[i] <= 1'b0;
                sync2[i] <= 1'b0;
            end else begin
                sync1[i] <= req_in[i];
                sync2[i] <= sync1[i];
            end
        end
    end

    assign req_s = sync2;
`else
    assign req_s = req_in;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) req_q <= '0;
        else        req_q <= req_s;
    end

    assign req_edge = req_s & ~req_q;

endmodule

// File: rtl/irq_request_latch.sv
// Sticky request capture feeding the priority encoder and a valid/ready consumer.
// Define IRQ_REQ_SYNC_EN to synchronize req_in (adds 2 cycles of latency).
module irq_request_latch
    import irq_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_in,
    input  logic [N_REQ-1:0] mask,
    input  logic             clr_all,
    output logic [N_REQ-1:0] pend_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [N_REQ-1:0] overflow
);

    logic [N_REQ-1:0] req_edge;
    logic [N_REQ-1:0] pending;
    logic [N_REQ-1:0] pending_nxt;
    logic [N_REQ-1:0] overflow_nxt;
    logic [N_REQ-1:0] acc_clr;
    logic [N_REQ-1:0] avail;
    logic             accept;
    irq_state_t       state;
    irq_state_t       state_nxt;
    logic [IDX_W-1:0] idx_nxt;

    req_edge_detect #(.N_REQ(N_REQ)) u_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_in   (req_in),
        .req_edge (req_edge)
    );

    assign out_valid = (state == PRESENT);
    assign accept    = out_valid & out_ready;
    assign acc_clr   = accept ? (N_REQ'(1) << out_idx) : '0;
    assign avail     = pending & ~mask;

    // A new edge beats an accept clear on the same bit, so the event is not lost.
    always_comb begin
        pending_nxt  = (pending & ~acc_clr) | req_edge;
        overflow_nxt = overflow | (req_edge & pending & ~acc_clr);
        if (clr_all) begin
            pending_nxt  = '0;
            overflow_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= '0;
            overflow <= '0;
            pend_vec <= '0;
        end else begin
            pending  <= pending_nxt;
            overflow <= overflow_nxt;
            pend_vec <= pending_nxt & ~mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            out_idx <= '0;
        end else begin
            state   <= state_nxt;
            out_idx <= idx_nxt;
        end
    end

    // Index is latched on entry to PRESENT and frozen until the handshake completes.
    always_comb begin
        state_nxt = state;
        idx_nxt   = out_idx;
        case (state)
            IDLE: begin
                if (|avail) begin
                    state_nxt = PRESENT;
                    idx_nxt   = highest_idx(avail);
                end
            end
            PRESENT: begin
                if (accept) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (clr_all) state_nxt = IDLE;
    end

endmodule

// File: tb/tb_irq_request_latch.sv
// Directed-vector bench for irq_request_latch; timing adapts to IRQ_REQ_SYNC_EN.
module tb_irq_request_latch;

`ifdef IRQ_REQ_SYNC_EN
    localparam int E = 2;
`else
    localparam int E = 0;
`endif

    logic       clk;
    logic       rst_n;
    logic [3:0] req_in;
    logic [3:0] mask;
    logic       clr_all;
    logic [3:0] pend_vec;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_idx;
    logic [3:0] overflow;

    int checks;
    int failures;

    irq_request_latch dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_in    (req_in),
        .mask      (mask),
        .clr_all   (clr_all),
        .pend_vec  (pend_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_in = '0; mask = '0; clr_all = 1'b0; out_ready = 1'b0;
        step(3);
        checks++;
        if ({pend_vec, out_valid, out_idx, overflow} !== 11'b0) begin
            failures++;
            $display("FAIL reset_outputs: got pend=%b valid=%b idx=%0d ovf=%b, want all 0",
                     pend_vec, out_valid, out_idx, overflow);
        end
        rst_n = 1'b1;
        step(2);
        checks++;
        if (out_valid !== 1'b0 || pend_vec !== 4'b0000) begin
            failures++;
            $display("FAIL reset_idle: got valid=%b pend=%b, want 0 0000", out_valid, pend_vec);
        end
    endtask

    task automatic test_single;
        req_in = 4'b0001;
        step(1);
        req_in = 4'b0000;
        step(E);
        checks++;
        if (pend_vec !== 4'b0001 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_pend: got pend=%b valid=%b, want 0001 0", pend_vec, out_valid);
        end
        step(1);
        checks++;
        if (out_valid !== 1'b1 || out_idx !== 2'd0) begin
            failures++;
            $display("FAIL single_present: got valid=%b idx=%0d, want 1 0", out_valid, out_idx);
        end
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || pend_vec !== 4'b0000) begin
            failures++;
            $display("FAIL single_accept: got valid=%b pend=%b, want 0 0000", out_valid, pend_vec);
        end
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        req_in = 4'b1010;
        step(1);
        req_in = 4'b0000;
        step(E);
        checks++;
        if (pend_vec !== 4'b1010 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_pend: got pend=%b valid=%b, want 1010 0", pend_vec, out_valid);
        end
        step(1);
        checks++;
        if (out_valid !== 1'b1 || out_idx !== 2'd3) begin
            failures++;
            $display("FAIL b2b_grant0: got valid=%b idx=%0d, want 1 3", out_valid, out_idx);
        end
        step(1);
        checks++;
        if (out_valid !== 1'b0 || pend_vec !== 4'b0010) begin
            failures++;
            $display("FAIL b2b_bubble: got valid=%b pend=%b, want 0 0010", out_valid, pend_vec);
        end
        step(1);
        checks++;
        if (out_valid !== 1'b1 || out_idx !== 2'd1) begin
            failures++;
            $display("FAIL b2b_grant1: got valid=%b idx=%0d, want 1 1", out_valid, out_idx);
        end
        step(1);
        checks++;
        if (out_valid !== 1'b0 || pend_vec !== 4'b0000) begin
            failures++;
            $display("FAIL b2b_done: got valid=%b pend=%b, want 0 0000", out_valid, pend_vec);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_mask;
        mask = 4'b1000;
        req_in = 4'b1001;
        step(1);
        req_in = 4'b0000;
        step(E);
        checks++;
        if (pend_vec !== 4'b0001) begin
            failures++;
            $display("FAIL mask_pend: got pend=%b, want 0001", pend_vec);
        end
        step(1);
        checks++;
        if (out_valid !== 1'b1 || out_idx !== 2'd0) begin
            failures++;
            $display("FAIL mask_present: got valid=%b idx=%0d, want 1 0", out_valid, out_idx);
        end
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || pend_vec !== 4'b0000) begin
            failures++;
            $display("FAIL mask_hidden: got valid=%b pend=%b, want 0 0000", out_valid, pend_vec);
        end
        mask = 4'b0000;
        step(1);
        checks++;
        if (out_valid !== 1'b1 || out_idx !== 2'd3 || pend_vec !== 4'b1000) begin
            failures++;
            $display("FAIL mask_release: got valid=%b idx=%0d pend=%b, want 1 3 1000",
                     out_valid, out_idx, pend_vec);
        end
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || pend_vec !== 4'b0000) begin
            failures++;
            $display("FAIL mask_drain: got valid=%b pend=%b, want 0 0000", out_valid, pend_vec);
        end
    endtask

    // Edge on the presented bit arrives exactly at the accept edge: bit must stay pending.
    task automatic test_edge_vs_accept;
        req_in = 4'b0010;
        step(1);
        req_in = 4'b0000;
        step(E + 1);
        checks++;
        if (out_valid !== 1'b1 || out_idx !== 2'd1) begin
            failures++;
            $display("FAIL eva_present: got valid=%b idx=%0d, want 1 1", out_valid, out_idx);
        end
        req_in = 4'b0010;
        for (int i = 0; i < E; i++) begin
            step(1);
            req_in = 4'b0000;
        end
        out_ready = 1'b1;
        step(1);
        req_in = 4'b0000;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || pend_vec !== 4'b0010 || overflow !== 4'b0000) begin
            failures++;
            $display("FAIL eva_kept: got valid=%b pend=%b ovf=%b, want 0 0010 0000",
                     out_valid, pend_vec, overflow);
        end
        step(1);
        checks++;
        if (out_valid !== 1'b1 || out_idx !== 2'd1) begin
            failures++;
            $display("FAIL eva_represent: got valid=%b idx=%0d, want 1 1", out_valid, out_idx);
        end
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || pend_vec !== 4'b0000) begin
            failures++;
            $display("FAIL eva_drain: got valid=%b pend=%b, want 0 0000", out_valid, pend_vec);
        end
    endtask

    // Leaves the block in PRESENT with pending = 0110 for test_clr_all.
    task automatic test_hold_overflow;
        req_in = 4'b0010;
        step(1);
        req_in = 4'b0000;
        step(E + 1);
        for (int i = 0; i < 10; i++) begin
            req_in = (i == 0) ? 4'b0100 : (i == 2) ? 4'b0010 : 4'b0000;
            step(1);
            checks++;
            if (out_valid !== 1'b1 || out_idx !== 2'd1) begin
                failures++;
                $display("FAIL hold_stable[%0d]: got valid=%b idx=%0d, want 1 1",
                         i, out_valid, out_idx);
            end
        end
        checks++;
        if (overflow !== 4'b0010 || pend_vec !== 4'b0110) begin
            failures++;
            $display("FAIL hold_overflow: got ovf=%b pend=%b, want 0010 0110", overflow, pend_vec);
        end
    endtask

    task automatic test_clr_all;
        clr_all = 1'b1;
        step(1);
        clr_all = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || pend_vec !== 4'b0000 || overflow !== 4'b0000) begin
            failures++;
            $display("FAIL clr_flush: got valid=%b pend=%b ovf=%b, want 0 0000 0000",
                     out_valid, pend_vec, overflow);
        end
        step(3);
        checks++;
        if (out_valid !== 1'b0 || pend_vec !== 4'b0000) begin
            failures++;
            $display("FAIL clr_quiet: got valid=%b pend=%b, want 0 0000", out_valid, pend_vec);
        end
    endtask

    // A level held high must be serviced exactly once.
    task automatic test_level;
        int grants;
        grants = 0;
        out_ready = 1'b1;
        req_in = 4'b0100;
        for (int i = 0; i < 8 + E; i++) begin
            step(1);
            if (out_valid === 1'b1) grants++;
        end
        checks++;
        if (grants !== 1 || overflow !== 4'b0000) begin
            failures++;
            $display("FAIL level_once: got grants=%0d ovf=%b, want 1 0000", grants, overflow);
        end
        req_in = 4'b0000;
        out_ready = 1'b0;
        step(2);
    endtask

    task automatic test_latency;
        int lat;
        lat = -1;
        req_in = 4'b0100;
        step(1);
        req_in = 4'b0000;
        for (int i = 1; i <= 8 && lat < 0; i++) begin
            if (out_valid === 1'b1) lat = i;
            else step(1);
        end
        checks++;
        if (lat !== 2 + E || out_idx !== 2'd2) begin
            failures++;
            $display("FAIL latency: got cycles=%0d idx=%0d, want %0d 2", lat, out_idx, 2 + E);
        end
    endtask

    // Entered while presenting idx 2 from test_latency.
    task automatic test_async_reset;
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL areset_pre: got valid=%b, want 1", out_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pend_vec, out_valid, out_idx, overflow} !== 11'b0) begin
            failures++;
            $display("FAIL areset_drop: got pend=%b valid=%b idx=%0d ovf=%b, want all 0",
                     pend_vec, out_valid, out_idx, overflow);
        end
        step(1);
        rst_n = 1'b1;
        step(1);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_mask();
        test_edge_vs_accept();
        test_hold_overflow();
        test_clr_all();
        test_level();
        test_latency();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/irq_request_latch.md
Name: irq_request_latch

Overview:
- Upstream request-capture stage for the 4-input priority encoder.
- Detects rising edges on raw request lines and holds them as sticky pending bits.
- Drives the encoder's request vector and presents the highest-priority unmasked pending index to a consumer over a valid/ready handshake.
- Clears each pending bit on acceptance, converting level-agnostic event requests into one-shot serviced events.

Parameters:
- N_REQ, 4, number of request lines.
- IDX_W, 2, index width; must equal clog2(N_REQ).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_in  input  N_REQ  raw request lines; bit i = source i.
- mask  input  N_REQ  1 = source blocked from presentation; its pending bit is still kept.
- clr_all  input  1  synchronous flush of all pending and overflow state.
- pend_vec  output  N_REQ  registered pending AND NOT mask; feeds the priority encoder inputs.
- out_valid  output  1  out_idx holds a serviceable request.
- out_ready  input  1  consumer accepts when high together with out_valid.
- out_idx  output  IDX_W  index of the presented request.
- overflow  output  N_REQ  sticky; an edge arrived while that bit was already pending.

Behaviour:
- Reset, asynchronous on rst_n low: pending, overflow, edge history, out_valid, out_idx and pend_vec all 0; FSM = IDLE.
- Edge detect:
  - req_q holds the previous sample.
  - edge[i] = req_in[i] & ~req_q[i].
  - A level held high sets pending exactly once.
- Pending update, in priority order:
  1. clr_all
  2. set by edge
  3. clear by accept
- If an edge and an accept clear hit the same bit in the same cycle, the bit stays pending.
- overflow[i] sets when edge[i] occurs while pending[i] = 1 and the bit is not being cleared this cycle. It clears only on clr_all or reset.
- Priority: highest index wins (bit 3 > bit 0), matching the downstream encoder.
- FSM has two states, IDLE and PRESENT:
  - IDLE: if any bit of pending & ~mask is set, register out_idx = highest such index, set out_valid = 1, go to PRESENT. Otherwise stay in IDLE.
  - PRESENT: out_idx and out_valid hold stable until out_valid & out_ready. On accept: clear pending[out_idx], out_valid = 0, return to IDLE.
  - Back-to-back requests therefore take a minimum of 2 cycles each (one bubble).
  - Mask changes and new higher-priority edges during PRESENT do not change out_idx or withdraw out_valid.
- clr_all:
  - Next cycle: pending = 0, overflow = 0, out_valid = 0, FSM = IDLE.
  - A handshake in the same cycle as clr_all is treated as accepted; no further side effect.
- Latency without the optional feature:
  - Edge sampled at cycle N.
  - pending and pend_vec visible at N+1.
  - out_valid at N+2 if FSM is IDLE.
- pend_vec is registered and is recomputed every cycle from pending and mask.
- Reset asserted mid-PRESENT drops out_valid immediately (asynchronously).

Optional Feature:
- Macro: IRQ_REQ_SYNC_EN.
- Defined: each req_in bit passes through a 2-flop synchronizer before edge detect. Latency grows by 2 cycles (out_valid at N+4). Synchronizer flops reset to 0.
- Undefined: req_in is assumed synchronous to clk and goes straight to edge detect.

Decomposition:
- Shared package irq_pkg holds:
  - N_REQ_DEF = 4 and IDX_W_DEF = 2.
  - FSM state typedef {IDLE, PRESENT}.
  - A function returning the highest set index of an N_REQ vector. The encoder model reuses this function.
- One sub-module, req_edge_detect (N_REQ wide), owns:
  - the optional synchronizer;
  - req_q;
  - the edge output.
- The top block keeps pending/overflow bookkeeping and the FSM.

Test Plan:
- Reset, then a single pulse req_in = 4'b0001 at cycle 5:
  - pend_vec = 0001 at cycle 6.
  - out_valid = 1, out_idx = 0 at cycle 7.
  - With out_ready = 1: out_valid = 0 and pend_vec = 0000 at cycle 8.
- Simultaneous req_in = 4'b1010, out_ready held 1:
  - Grants are out_idx = 3, then out_idx = 1, each 2 cycles apart.
  - pend_vec goes 1010, then 0010, then 0000.
- mask = 4'b1000 with req_in edge 4'b1001:
  - out_idx = 0 is presented; pending[3] stays 1.
  - Drop mask to 0 → out_idx = 3 is presented next.
- Hold out_ready = 0 for 10 cycles while presenting idx 1:
  - A new edge on bit 2 leaves out_idx = 1 stable.
  - A second edge on bit 1 sets overflow = 4'b0010.
- In PRESENT with pending = 4'b0110, pulse clr_all:
  - Next cycle: out_valid = 0, pend_vec = 0000, overflow = 0000.
- Build with IRQ_REQ_SYNC_EN, edge on bit 2 at cycle N:
  - out_valid = 1, out_idx = 2 at N+4.
- Assert rst_n = 0 mid-PRESENT:
  - All outputs read 0 before the next clk edge.
